// File: rtl/regalu_arb_pkg.sv
// Shared types and width constants for the RegFile_Alu request arbiter.
package regalu_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int OP_W   = 4;
  localparam int FLAG_W = 5;

  localparam logic [3:0] OP_ADD = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/regalu_arbiter_rr_arb2.sv
// Combinational two-input arbiter: round-robin by default, fixed priority
// (requester 0 first) when REGALU_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import regalu_arb_pkg::*;
(
  input  logic [1:0] req,
`ifndef REGALU_ARB_FIXED_PRIO_EN
  input  logic       last,
`endif
  output logic       winner,
  output logic       any
);

  assign any = |req;

`ifdef REGALU_ARB_FIXED_PRIO_EN
  assign winner = req[1] & ~req[0];
`else
  // on a tie the requester not granted last time wins
  assign winner = (&req) ? ~last : req[1];
`endif

endmodule

// File: rtl/regalu_arbiter.sv
// Two-master arbiter/sequencer for the single RegFile_Alu: IDLE/ISSUE/READ/RESP.
// Define REGALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module regalu_arbiter #(
  parameter int DATA_W = regalu_arb_pkg::DATA_W,
  parameter int ADDR_W = regalu_arb_pkg::ADDR_W,
  parameter int OP_W   = regalu_arb_pkg::OP_W,
  parameter int FLAG_W = regalu_arb_pkg::FLAG_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0,
  input  logic [OP_W-1:0]   op0,
  input  logic [ADDR_W-1:0] dest0,
  input  logic [ADDR_W-1:0] src0,
  input  logic [DATA_W-1:0] imm0,
  input  logic              imm_s0,
  input  logic              req1,
  input  logic [OP_W-1:0]   op1,
  input  logic [ADDR_W-1:0] dest1,
  input  logic [ADDR_W-1:0] src1,
  input  logic [DATA_W-1:0] imm1,
  input  logic              imm_s1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags,
  output logic [ADDR_W-1:0] RdestRegLoc,
  output logic [ADDR_W-1:0] RsrcRegLoc,
  output logic [OP_W-1:0]   OpCode,
  output logic [DATA_W-1:0] Imm,
  output logic              Imm_s,
  output logic              En,
  input  logic [DATA_W-1:0] RdestOut,
  input  logic [FLAG_W-1:0] Flags
);
  import regalu_arb_pkg::*;

  logic [1:0]             w_req;
  logic [1:0][OP_W-1:0]   w_op;
  logic [1:0][ADDR_W-1:0] w_dest;
  logic [1:0][ADDR_W-1:0] w_src;
  logic [1:0][DATA_W-1:0] w_imm;
  logic [1:0]             w_imm_s;
  logic                   w_winner;
  logic                   w_any;

  state_t                 r_state;
  logic                   r_owner;
  logic [1:0]             r_gnt;
  logic [1:0]             r_done;
  logic                   r_en;
  logic [OP_W-1:0]        r_op;
  logic [ADDR_W-1:0]      r_dest;
  logic [ADDR_W-1:0]      r_src;
  logic [DATA_W-1:0]      r_imm;
  logic                   r_imm_s;
  logic [DATA_W-1:0]      r_result;
  logic [FLAG_W-1:0]      r_flags;
`ifndef REGALU_ARB_FIXED_PRIO_EN
  logic                   r_last;
`endif

  assign w_req   = {req1, req0};
  assign w_op    = {op1, op0};
  assign w_dest  = {dest1, dest0};
  assign w_src   = {src1, src0};
  assign w_imm   = {imm1, imm0};
  assign w_imm_s = {imm_s1, imm_s0};

  rr_arb2 u_arb (
    .req    (w_req),
`ifndef REGALU_ARB_FIXED_PRIO_EN
    .last   (r_last),
`endif
    .winner (w_winner),
    .any    (w_any)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_en     <= 1'b0;
      r_op     <= '0;
      r_dest   <= '0;
      r_src    <= '0;
      r_imm    <= '0;
      r_imm_s  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
`ifndef REGALU_ARB_FIXED_PRIO_EN
      r_last   <= 1'b1;
`endif
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_en   <= 1'b0;
      case (r_state)
        // a req still high in RESP is a fresh request, so both states arbitrate
        IDLE, RESP: begin
          if (w_any) begin
            r_state          <= ISSUE;
            r_owner          <= w_winner;
            r_gnt[w_winner]  <= 1'b1;
            r_en             <= 1'b1;
            r_op             <= w_op[w_winner];
            r_dest           <= w_dest[w_winner];
            r_src            <= w_src[w_winner];
            r_imm            <= w_imm[w_winner];
            r_imm_s          <= w_imm_s[w_winner];
`ifndef REGALU_ARB_FIXED_PRIO_EN
            r_last           <= w_winner;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: r_state <= READ;
        READ: begin
          r_result        <= RdestOut;
          r_flags         <= Flags;
          r_done[r_owner] <= 1'b1;
          r_state         <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0        = r_gnt[0];
  assign gnt1        = r_gnt[1];
  assign done0       = r_done[0];
  assign done1       = r_done[1];
  assign result      = r_result;
  assign flags       = r_flags;
  assign En          = r_en;
  assign OpCode      = r_op;
  assign RdestRegLoc = r_dest;
  assign RsrcRegLoc  = r_src;
  assign Imm         = r_imm;
  assign Imm_s       = r_imm_s;

endmodule

// File: tb/tb_regalu_arbiter.sv
// Scoreboard bench for regalu_arbiter with a stand-in RegFile_Alu.
module tb_regalu_arbiter;
  import regalu_arb_pkg::*;

`ifdef REGALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic              s_req  [2];
  logic [OP_W-1:0]   s_op   [2];
  logic [ADDR_W-1:0] s_dest [2];
  logic [ADDR_W-1:0] s_src  [2];
  logic [DATA_W-1:0] s_imm  [2];
  logic              s_ims  [2];

  logic              gnt0, gnt1, done0, done1, En, Imm_s;
  logic [DATA_W-1:0] result, Imm, rf_out;
  logic [FLAG_W-1:0] flags, rf_flags;
  logic [ADDR_W-1:0] RdestRegLoc, RsrcRegLoc;
  logic [OP_W-1:0]   OpCode;

  regalu_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .req0(s_req[0]), .op0(s_op[0]), .dest0(s_dest[0]), .src0(s_src[0]),
    .imm0(s_imm[0]), .imm_s0(s_ims[0]),
    .req1(s_req[1]), .op1(s_op[1]), .dest1(s_dest[1]), .src1(s_src[1]),
    .imm1(s_imm[1]), .imm_s1(s_ims[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .flags(flags),
    .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
    .OpCode(OpCode), .Imm(Imm), .Imm_s(Imm_s), .En(En),
    .RdestOut(rf_out), .Flags(rf_flags)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU used by the stand-in register file and by the reference model.
  function automatic logic [FLAG_W+DATA_W-1:0] alu(input logic [OP_W-1:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   s;
    logic [DATA_W-1:0] r;
    logic              c;
    c = 1'b0;
    s = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[DATA_W-1:0]; c = s[DATA_W]; end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[DATA_W-1:0]; c = s[DATA_W]; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = b;
    endcase
    return {c, (r == '0), r[DATA_W-1], ^r, op[0], r};
  endfunction

  // Stand-in RegFile_Alu: write on En, RdestOut reads the addressed register.
  logic [DATA_W-1:0]        rf [16];
  logic [FLAG_W+DATA_W-1:0] w_alu;
  assign w_alu  = alu(OpCode, rf[RdestRegLoc], Imm_s ? Imm : rf[RsrcRegLoc]);
  assign rf_out = rf[RdestRegLoc];
  always @(posedge Clk) begin
    if (En) begin
      rf[RdestRegLoc] <= w_alu[DATA_W-1:0];
      rf_flags        <= w_alu[FLAG_W+DATA_W-1:DATA_W];
    end
  end

  // Transaction-level reference: register contents and arbitration history.
  typedef struct {
    logic              id;
    logic [DATA_W-1:0] res;
    logic [FLAG_W-1:0] flg;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] rf_ref [16];
  logic [1:0]        m_snap = 2'b00;
  logic              m_last = 1'b1;
  logic [DATA_W-1:0] m_hres = '0;
  logic [FLAG_W-1:0] m_hflg = '0;

  always @(negedge Clk) begin
    logic                     w, pred;
    logic [DATA_W-1:0]        b;
    logic [FLAG_W+DATA_W-1:0] v;
    exp_t                     e;
    if (!Rst) begin
      chk("quiet_in_reset", {27'd0, En, gnt1, gnt0, done1, done0}, 32'd0);
      q.delete();
      m_last = 1'b1;
      m_hres = '0;
      m_hflg = '0;
    end else begin
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("done_excl", done0 & done1, 0);
      chk("en_eq_gnt", En, gnt0 | gnt1);
      if (gnt0 | gnt1) begin
        w    = gnt1;
        pred = (m_snap == 2'b11) ? (FIXED ? 1'b0 : ~m_last) : m_snap[1];
        chk("winner", w, pred);
        m_last = w;
        chk("opcode", OpCode, s_op[w]);
        chk("rdest", RdestRegLoc, s_dest[w]);
        chk("rsrc", RsrcRegLoc, s_src[w]);
        chk("imm", Imm, s_imm[w]);
        chk("imm_s", Imm_s, s_ims[w]);
        b = s_ims[w] ? s_imm[w] : rf_ref[s_src[w]];
        v = alu(s_op[w], rf_ref[s_dest[w]], b);
        rf_ref[s_dest[w]] = v[DATA_W-1:0];
        e.id  = w;
        e.res = v[DATA_W-1:0];
        e.flg = v[FLAG_W+DATA_W-1:DATA_W];
        q.push_back(e);
      end
      if (done0 | done1) begin
        if (q.size() == 0) begin
          chk("done_unexpected", {30'd0, done1, done0}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_id", done1, e.id);
          chk("result", result, e.res);
          chk("flags", flags, e.flg);
          m_hres = e.res;
          m_hflg = e.flg;
        end
      end else begin
        chk("result_hold", result, m_hres);
        chk("flags_hold", flags, m_hflg);
      end
    end
    m_snap = {s_req[1], s_req[0]};
  end

  task automatic wait_gnt(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge Clk); #1;
      ok = (n == 1) ? gnt1 : gnt0;
    end
    chk($sformatf("gnt%0d_wait", n), ok, 1);
    s_req[n] = 1'b0;
  endtask

  task automatic wait_done(input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge Clk); #1;
      ok = (n == 1) ? done1 : done0;
    end
    chk($sformatf("done%0d_wait", n), ok, 1);
  endtask

  task automatic set_rand(input int n);
    s_op[n]   = OP_W'($urandom_range(6, 0));
    s_dest[n] = ADDR_W'($urandom);
    s_src[n]  = ADDR_W'($urandom);
    s_imm[n]  = DATA_W'($urandom);
    s_ims[n]  = 1'($urandom);
  endtask

  task automatic rnd_driver(input int n);
    logic ok;
    for (int t = 0; t < 15; t++) begin
      repeat ($urandom_range(3, 1)) @(posedge Clk);
      #1;
      set_rand(n);
      s_req[n] = 1'b1;
      wait_gnt(n, ok);
      wait_done(n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected summary before t=200000");
    $fatal(1);
  end

  initial begin
    logic ok, saw0, saw1, exp_first;
    int   gid [6];
    int   gcyc[6];
    int   k;
    for (int i = 0; i < 16; i++) begin
      rf[i]     <= DATA_W'(16'h1111 * i);
      rf_ref[i]  = DATA_W'(16'h1111 * i);
    end
    rf_flags <= '0;
    for (int n = 0; n < 2; n++) begin
      s_req[n] = 1'b0; s_op[n] = '0; s_dest[n] = '0;
      s_src[n] = '0; s_imm[n] = '0; s_ims[n] = 1'b0;
    end

    // Reset with req0 held; first op ADD R1 += 5
    s_op[0] = OP_ADD; s_dest[0] = 4'd1; s_src[0] = 4'd0; s_imm[0] = 16'd5; s_ims[0] = 1'b1;
    s_req[0] = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk); #2 Rst = 1'b1;
    @(posedge Clk); #1;
    chk("t1_gnt0_c1", gnt0, 1);
    chk("t1_en_c1", En, 1);
    chk("t1_result_pre", result, 0);
    chk("t1_flags_pre", flags, 0);
    s_req[0] = 1'b0;
    @(posedge Clk); #1;
    chk("t1_en_read", En, 0);
    chk("t1_result_read", result, 0);
    @(posedge Clk); #1;
    chk("t1_done0_c3", done0, 1);
    chk("t1_result", result, 16'h1116);
    @(posedge Clk); #1;
    chk("t1_done_pulse", done0, 0);
    chk("t1_result_kept", result, 16'h1116);

    // Requester 1 alone, register source
    repeat (2) @(posedge Clk); #1;
    s_op[1] = OP_ADD; s_dest[1] = 4'd2; s_src[1] = 4'd1; s_imm[1] = 16'hBEEF; s_ims[1] = 1'b0;
    s_req[1] = 1'b1;
    wait_gnt(1, ok);
    saw0 = 1'b0; saw1 = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
      saw0 |= done0; saw1 |= done1;
    end
    chk("t4_done1", saw1, 1);
    chk("t4_no_done0", saw0, 0);
    chk("t4_result", result, 16'h2222 + 16'h1116);

    // Simultaneous held requests
    set_rand(0); set_rand(1);
    exp_first = FIXED ? 1'b0 : ~m_last;
    s_req[0] = 1'b1; s_req[1] = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 6; i++) begin
      @(posedge Clk); #1;
      if (gnt0 | gnt1) begin
        gid[k] = int'(gnt1); gcyc[k] = cyc; k++;
      end
    end
    s_req[0] = 1'b0; s_req[1] = 1'b0;
    chk("t3_count", k, 6);
    for (int i = 0; i < k; i++) begin
      chk("t3_order", gid[i], FIXED ? 0 : int'(exp_first ^ i[0]));
      if (i > 0) chk("t3_spacing", gcyc[i] - gcyc[i-1], 3);
    end
    repeat (6) @(posedge Clk);

    // Reset during READ aborts the op
    #1;
    set_rand(1);
    s_req[1] = 1'b1;
    wait_gnt(1, ok);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    chk("t5_en", En, 0);
    chk("t5_result", result, 0);
    chk("t5_flags", flags, 0);
    chk("t5_opcode", OpCode, 0);
    chk("t5_rdest", RdestRegLoc, 0);
    chk("t5_rsrc", RsrcRegLoc, 0);
    chk("t5_imm", {Imm_s, Imm}, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); #2 Rst = 1'b1;
    saw0 = 1'b0;
    repeat (4) begin
      @(posedge Clk); #1;
      saw0 |= done0 | done1;
    end
    chk("t5_no_done", saw0, 0);
    set_rand(0);
    s_req[0] = 1'b1;
    wait_gnt(0, ok);
    wait_done(0);

    // Randomized concurrent traffic
    fork
      rnd_driver(0);
      rnd_driver(1);
    join
    repeat (8) @(posedge Clk);
    chk("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regalu_arbiter.md
# regalu_arbiter

Two-requester arbiter and sequencer for the register-file/ALU datapath (`RegFile_Alu`). It accepts operation requests (opcode, destination and source register, immediate) from two independent masters and issues one write-enabled operation at a time. It returns the resulting destination value and flags to the granted master with a one-cycle done pulse. It sits between the control FSMs and the single `RegFile_Alu` instance, replacing direct FSM drive of its control inputs.

## Interface
- DATA_W, 16, datapath / immediate / result width
- ADDR_W, 4, register address width
- OP_W, 4, opcode width
- FLAG_W, 5, ALU flag width

- Clk  in  1  single clock; all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-low
- reqN (N=0,1)  in  1  request; held high with operands stable until gntN
- opN / destN / srcN  in  OP_W / ADDR_W / ADDR_W  opcode, Rdest, Rsrc
- immN, imm_sN  in  DATA_W, 1  immediate value, immediate select
- gntN  out  1  one-cycle pulse: request accepted, operands captured
- doneN  out  1  one-cycle pulse: result/flags valid for requester N
- result  out  DATA_W  captured RdestOut of the last completed op
- flags  out  FLAG_W  captured Flags of the last completed op
- RdestRegLoc, RsrcRegLoc  out  ADDR_W  to RegFile_Alu
- OpCode  out  OP_W; Imm  out  DATA_W; Imm_s  out  1; En  out  1  to RegFile_Alu
- RdestOut  in  DATA_W; Flags  in  FLAG_W  from RegFile_Alu

## Operation
- States: IDLE, ISSUE, READ, RESP.
- IDLE: if any reqN is high at the edge, pick a winner, latch its operands into op registers, set owner, go to ISSUE. Otherwise stay.
- ISSUE: En=1; datapath controls driven from the op registers; gnt[owner]=1. Go to READ.
- READ: En=0; controls hold their values. At the edge, capture RdestOut into result and Flags into flags. Go to RESP.
- RESP: done[owner]=1. If the other requester's req is high, arbitrate and go directly to ISSUE (back-to-back). Else if the owner's req is high, it is a new request: arbitrate, go to ISSUE. Else go to IDLE.
- Arbitration, round-robin: on simultaneous requests, the requester not granted last wins. A single requester always wins. `last` is updated on every grant.
- A requester must drop reqN in the cycle after gntN. A req still high in RESP is a new request.
- Datapath control outputs are registered. En is high only in ISSUE.
- No arithmetic in this block. Widths pass through unchanged.

## Timing
- Reset (async, any state): state=IDLE; En=0; all gnt/done=0; result=0; flags=0; RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s = 0; `last`=1, so requester 0 wins the first tie.
- Reset mid-operation aborts the op; no done is ever issued for it.
- Latency: req sampled at edge k → gnt and En high in cycle k+1 → RegFile write at edge k+2 → done, result, flags valid in cycle k+3.
- Throughput: back-to-back ops every 3 cycles (ISSUE, READ, RESP).
- result/flags hold their values until the next READ capture.
- gnt and done are never high for both requesters in the same cycle.

## Configuration
- REGALU_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins simultaneous requests, and `last` is unused and removed. When undefined, round-robin as above.

## Structure
- Package regalu_arb_pkg holds:
  - the state enum (IDLE, ISSUE, READ, RESP);
  - width constants DATA_W, ADDR_W, OP_W, FLAG_W;
  - opcode constant OP_ADD=4'b0000.
- One sub-module: rr_arb2, a combinational two-input arbiter with a `last` input and `winner`/`any` outputs. It holds the fixed-priority variant under the macro.

## Test plan
- Reset with req0=1 held → no gnt or En during reset. After release: gnt0 in cycle 1, En=1 in cycle 1, done0 in cycle 3, result and flags = 0 before capture.
- req0: op=ADD, dest=1, imm=5, imm_s=1 → En pulse with RdestRegLoc=1, Imm=5. done0 with result=R1_old+5, flags match RegFile_Alu.
- req0 and req1 asserted in the same cycle, held → grants alternate 0, 1, 0, 1, spaced 3 cycles apart. With REGALU_ARB_FIXED_PRIO_EN: 0, 0, 0 while req0 is held.
- req1 only, dest=2, src=1, imm_s=0 → RsrcRegLoc=1, RdestRegLoc=2, done1 only, done0 never high.
- Rst asserted during READ → En=0 and outputs=0 immediately. No done. Next request after release is served normally from IDLE.
